// File: rtl/piano_pkg.sv
// Shared voice state encoding and key width for the polyphonic note player.
package piano_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } voice_state_t;

    localparam int KEY_W = 8;
endpackage

// File: rtl/note_voice.sv
// One square-wave voice: loads on start_i, rings for dur_i cycles toggling every half_i cycles.
// Next-cycle response to start/stop; start wins over expiry so a retrigger on the last cycle keeps ringing.
module note_voice
    import piano_pkg::*;
#(
    parameter int DIV_W = 17,
    parameter int DUR_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [DIV_W-1:0] half_i,
    input  logic [DUR_W-1:0] dur_i,
    output logic             ring_o,
    output logic             level_o,
    output logic [KEY_W-1:0] key_o
);

    voice_state_t     state_q;
    logic [KEY_W-1:0] key_q;
    logic [DIV_W-1:0] half_q;
    logic [DUR_W-1:0] dur_q;
    logic [DIV_W-1:0] div_q;
    logic             level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            key_q   <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            div_q   <= '0;
            level_q <= 1'b0;
        end else if (start_i) begin
            state_q <= RING;
            key_q   <= key_i;
            half_q  <= half_i;
            dur_q   <= dur_i;
            div_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                RING: begin
                    // dur_q==1 marks the final ringing cycle
                    if (stop_i || dur_q == DUR_W'(1)) begin
                        state_q <= IDLE;
                        dur_q   <= '0;
                        div_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        dur_q <= dur_q - DUR_W'(1);
                        if (div_q == half_q - DIV_W'(1)) begin
                            div_q   <= '0;
                            level_q <= ~level_q;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ring_o  = (state_q == RING);
    assign level_o = level_q;
    assign key_o   = key_q;

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic square-wave player: voice allocation by key plus sigma-delta mixer to a 1-bit stream.
// Voices react one cycle after acceptance; oNoteReady drops only when a new press finds no voice (always 1 with POLY_NOTE_PLAYER_VOICE_STEAL_EN).
module poly_note_player
    import piano_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int DIV_W  = 17,
    parameter int DUR_W  = 26
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iNoteValid,
    output logic              oNoteReady,
    input  logic              iNoteOff,
    input  logic [KEY_W-1:0]  iNoteKey,
    input  logic [DIV_W-1:0]  iNoteHalfPeriod,
    input  logic [DUR_W-1:0]  iDuration,
    output logic              oPWM,
    output logic [VOICES-1:0] oActive
);

    localparam int AW = $clog2(VOICES) + 1;

    logic [VOICES-1:0] ring, level, match, match_sel, idle_sel, start_sel, stop_sel;
    logic [KEY_W-1:0]  voice_key [VOICES];
    logic              found_idle, found_match, any_match, any_idle, rest, accept, press;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        note_voice #(
            .DIV_W(DIV_W),
            .DUR_W(DUR_W)
        ) u_voice (
            .clk_i  (iClk),
            .rst_i  (iReset),
            .start_i(start_sel[g]),
            .stop_i (stop_sel[g]),
            .key_i  (iNoteKey),
            .half_i (iNoteHalfPeriod),
            .dur_i  (iDuration),
            .ring_o (ring[g]),
            .level_o(level[g]),
            .key_o  (voice_key[g])
        );
        assign match[g] = ring[g] && (voice_key[g] == iNoteKey);
    end

    always_comb begin
        idle_sel    = '0;
        match_sel   = '0;
        found_idle  = 1'b0;
        found_match = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (!ring[i] && !found_idle) begin
                idle_sel[i] = 1'b1;
                found_idle  = 1'b1;
            end
            if (match[i] && !found_match) begin
                match_sel[i] = 1'b1;
                found_match  = 1'b1;
            end
        end
    end

    assign any_match = |match;
    assign any_idle  = |idle_sel;
    assign rest      = (iNoteHalfPeriod == '0) || (iDuration == '0);
    assign accept    = iNoteValid && oNoteReady && !iReset;
    assign press     = accept && !iNoteOff && !rest;
    assign stop_sel  = (accept && iNoteOff) ? match : '0;

`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
    localparam int PW = $clog2(VOICES);
    logic [PW-1:0]     steal_ptr_q, steal_ptr_d;
    logic [VOICES-1:0] steal_sel;
    logic              steal;

    assign steal = press && !any_match && !any_idle;

    always_comb begin
        steal_sel              = '0;
        steal_sel[steal_ptr_q] = 1'b1;
        steal_ptr_d            = steal_ptr_q;
        if (steal) begin
            steal_ptr_d = (steal_ptr_q == PW'(VOICES - 1)) ? '0 : steal_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) steal_ptr_q <= '0;
        else        steal_ptr_q <= steal_ptr_d;
    end

    assign oNoteReady = 1'b1;
`else
    assign oNoteReady = iReset || iNoteOff || any_match || rest || any_idle;
`endif

    always_comb begin
        start_sel = '0;
        if (press) begin
            if (any_match)     start_sel = match_sel;
            else if (any_idle) start_sel = idle_sel;
`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
            else               start_sel = steal_sel;
`endif
        end
    end

    // First-order sigma-delta: pulse density on oPWM equals high voices / VOICES
    logic [AW-1:0] lvl_cnt, acc_q, acc_d;
    logic [AW:0]   sum;
    logic          pwm_q, pwm_d;

    always_comb begin
        lvl_cnt = '0;
        for (int i = 0; i < VOICES; i++) begin
            lvl_cnt = lvl_cnt + AW'(level[i]);
        end
        sum = {1'b0, acc_q} + {1'b0, lvl_cnt};
        if (sum >= (AW+1)'(VOICES)) begin
            acc_d = sum[AW-1:0] - AW'(VOICES);
            pwm_d = 1'b1;
        end else begin
            acc_d = sum[AW-1:0];
            pwm_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            acc_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pwm_q <= pwm_d;
        end
    end

    assign oPWM    = pwm_q;
    assign oActive = ring;

endmodule

// File: tb/tb_poly_note_player.sv
// Randomized and directed bench for poly_note_player against a cycle-level behavioural model.
module tb_poly_note_player;
    localparam int V = 4;

    logic          clk;
    logic          iReset, iNoteValid, oNoteReady, iNoteOff, oPWM;
    logic [7:0]    iNoteKey;
    logic [16:0]   iNoteHalfPeriod;
    logic [25:0]   iDuration;
    logic [V-1:0]  oActive;

    poly_note_player #(.VOICES(V), .DIV_W(17), .DUR_W(26)) dut (
        .iClk(clk), .iReset(iReset), .iNoteValid(iNoteValid), .oNoteReady(oNoteReady),
        .iNoteOff(iNoteOff), .iNoteKey(iNoteKey), .iNoteHalfPeriod(iNoteHalfPeriod),
        .iDuration(iDuration), .oPWM(oPWM), .oActive(oActive)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_run = 0;
    int n_fail = 0;
    int pwm_seen, act_seen, cnt;

    // Model: per voice ringing flag, key, half period, length and cycles elapsed since start
    bit m_ring [V];
    int m_key [V], m_half [V], m_dur [V], m_el [V];
    int m_acc, m_ptr;
    bit m_pwm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_level(int i);
        if (!m_ring[i] || m_half[i] == 0) return 1'b0;
        return ((m_el[i] / m_half[i]) % 2) == 1;
    endfunction

    function automatic int m_find();
        for (int i = 0; i < V; i++)
            if (m_ring[i] && m_key[i] == int'(iNoteKey)) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
        return 1'b1;
`else
        if (iReset || iNoteOff || iNoteHalfPeriod == 0 || iDuration == 0 || m_find() >= 0) return 1'b1;
        for (int i = 0; i < V; i++) if (!m_ring[i]) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic logic [V-1:0] m_active();
        logic [V-1:0] r;
        for (int i = 0; i < V; i++) r[i] = m_ring[i];
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < V; i++) begin
            m_ring[i] = 1'b0; m_key[i] = 0; m_half[i] = 0; m_dur[i] = 0; m_el[i] = 0;
        end
        m_acc = 0; m_ptr = 0; m_pwm = 1'b0;
    endtask

    task automatic m_step();
        int s = 0;
        int tgt = -1;
        int stp = -1;
        int mi;
        for (int i = 0; i < V; i++) s += int'(m_level(i));
        if (m_acc + s >= V) begin m_acc = m_acc + s - V; m_pwm = 1'b1; end
        else begin m_acc = m_acc + s; m_pwm = 1'b0; end
        if (iNoteValid && m_ready() && !iReset) begin
            mi = m_find();
            if (iNoteOff) stp = mi;
            else if (iNoteHalfPeriod != 0 && iDuration != 0) begin
                if (mi >= 0) tgt = mi;
                else begin
                    for (int i = V - 1; i >= 0; i--) if (!m_ring[i]) tgt = i;
`ifdef POLY_NOTE_PLAYER_VOICE_STEAL_EN
                    if (tgt < 0) begin tgt = m_ptr; m_ptr = (m_ptr + 1) % V; end
`endif
                end
            end
        end
        for (int i = 0; i < V; i++) begin
            if (i == tgt) begin
                m_ring[i] = 1'b1; m_key[i] = int'(iNoteKey); m_half[i] = int'(iNoteHalfPeriod);
                m_dur[i] = int'(iDuration); m_el[i] = 0;
            end else if (i == stp) begin
                m_ring[i] = 1'b0;
            end else if (m_ring[i]) begin
                m_el[i]++;
                if (m_el[i] >= m_dur[i]) m_ring[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit v, input bit off, input int k, input int h, input int d);
        @(negedge clk);
        iNoteValid = v; iNoteOff = off; iNoteKey = 8'(k);
        iNoteHalfPeriod = 17'(h); iDuration = 26'(d);
        #1;
        check("ready", 32'(oNoteReady), 32'(m_ready()));
        check("active", 32'(oActive), 32'(m_active()));
        check("pwm", 32'(oPWM), 32'(m_pwm));
        pwm_seen = int'(oPWM);
        act_seen = int'(oActive);
        @(posedge clk);
        m_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        iReset = 1'b1; iNoteValid = 1'b1; iNoteOff = 1'b0; iNoteKey = 8'h33;
        iNoteHalfPeriod = 17'd3; iDuration = 26'd9;
        #1;
        check("rst_active", 32'(oActive), 32'd0);
        check("rst_pwm", 32'(oPWM), 32'd0);
        check("rst_ready", 32'(oNoteReady), 32'd1);
        m_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_active", 32'(oActive), 32'd0);
        iReset = 1'b0; iNoteValid = 1'b0;
        @(posedge clk);
        m_step();
    endtask

    initial begin
        iReset = 1'b0; iNoteValid = 1'b0; iNoteOff = 1'b0; iNoteKey = '0;
        iNoteHalfPeriod = '0; iDuration = '0;
        m_clear();
        do_reset();

        cnt = 0;
        repeat (8) begin cycle(1'b0, 1'b0, 0, 0, 0); cnt += pwm_seen; end
        check("pwm_idle", 32'(cnt), 32'd0);

        cycle(1'b1, 1'b0, 'h1C, 4, 40);
        #1 check("note_on", 32'(oActive[0]), 32'd1);
        cnt = 0;
        repeat (50) begin idle(1); cnt += act_seen; end
        check("note_len", 32'(cnt), 32'd40);

        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, k, 3 + k, 300);
        repeat (3) cycle(1'b1, 1'b0, 4, 5, 300);
        cycle(1'b1, 1'b1, 2, 0, 0);
        cycle(1'b1, 1'b0, 4, 5, 300);
        #1 check("fifth_alloc", 32'(oActive), 32'hF);
        idle(5);

        do_reset();
        cycle(1'b1, 1'b0, 7, 5, 30);
        idle(10);
        cycle(1'b1, 1'b0, 7, 5, 30);
        #1 check("retrig_one", 32'(oActive), 32'd1);
        cnt = 0;
        repeat (40) begin idle(1); cnt += act_seen; end
        check("retrig_len", 32'(cnt), 32'd30);

        do_reset();
        cycle(1'b1, 1'b0, 1, 64, 400);
        cycle(1'b1, 1'b0, 2, 64, 400);
        cnt = 0;
        for (int j = 1; j <= 100; j++) begin
            idle(1);
            if (j >= 80 && j < 88) cnt += pwm_seen;
        end
        check("pwm_density", 32'(cnt), 32'd4);

        do_reset();
        cycle(1'b1, 1'b0, 3, 5, 100);
        cycle(1'b1, 1'b0, 9, 0, 50);
        cycle(1'b1, 1'b1, 99, 0, 0);
        #1 check("rest_keep", 32'(oActive), 32'd1);
        idle(3);

        repeat (3) begin
            do_reset();
            repeat (800) begin
                bit rv, roff;
                int rk, rh, rd;
                rv   = 1'($urandom_range(0, 1));
                roff = ($urandom_range(0, 3) == 0);
                rk   = int'($urandom_range(0, 5));
                rh   = int'($urandom_range(0, 6));
                rd   = int'($urandom_range(0, 40));
                cycle(rv, roff, rk, rh, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
